toy_bus_age_arb_lock: RTL and testbench

- Parametrised N-input request arbiter for the toy_bus network. It is the next generation of the 2-input ToyBusReq arbiter node.
- Arbitration is least-recently-granted, using an internal NxN age matrix.
- Adds multi-beat packet locking via a per-input last flag, grant hold under backpressure, and an optional output register slice.
- Sits at every shared target port (itcm/dtcm/periph) where more than two initiators merge.

---
 rtl/toy_bus_age_arb_lock.sv | 144 ++++++++++++++
 tb/tb_toy_bus_age_arb_lock.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/toy_bus_age_arb_lock.sv
// N-input least-recently-granted request arbiter for toy_bus target ports, with
// multi-beat packet locking, grant hold under backpressure and an optional output slice.
module toy_bus_age_arb_lock #(
    parameter int NUM_IN  = 4,
    parameter int PLD_W   = 77,
    parameter int OUT_REG = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_IN-1:0]         in_vld,
    output logic [NUM_IN-1:0]         in_rdy,
    input  logic [NUM_IN-1:0]         in_last,
    input  logic [NUM_IN*PLD_W-1:0]   in_pld,
    output logic                      out_vld,
    input  logic                      out_rdy,
    output logic                      out_last,
    output logic [PLD_W-1:0]          out_pld,
    output logic [$clog2(NUM_IN)-1:0] out_idx,
    output logic                      lock_active
);
    localparam int IDX_W = $clog2(NUM_IN);
    localparam logic [NUM_IN-1:0] ONE = {{(NUM_IN-1){1'b0}}, 1'b1};

    // r_age[i][j] = 1 means input j is older than input i
    logic [NUM_IN-1:0] r_age [NUM_IN];
    logic              r_lock_active;
    logic [IDX_W-1:0]  r_lock_idx;
    logic              r_hold_vld;
    logic [IDX_W-1:0]  r_hold_idx;

    logic [NUM_IN-1:0] w_elig;
    logic [NUM_IN-1:0] w_sel;
    logic [NUM_IN-1:0] w_gnt;
    logic [NUM_IN-1:0] w_act;
    logic              w_gnt_vld;
    logic              w_take;
    logic              w_hs;
    logic              w_last;
    logic [IDX_W-1:0]  w_gidx;
    logic [PLD_W-1:0]  w_pld;

    // Arbitration: lock narrows eligibility, a pending beat overrides the age pick
    always_comb begin
        w_elig = in_vld;
        if (r_lock_active) begin
            w_elig = in_vld & (ONE << r_lock_idx);
        end
        for (int i = 0; i < NUM_IN; i++) begin
            w_sel[i] = w_elig[i] & ~|(r_age[i] & w_elig & ~(ONE << i));
        end
        w_gnt     = r_hold_vld ? (ONE << r_hold_idx) : w_sel;
        w_act     = w_gnt & in_vld;
        w_gnt_vld = |w_act;
        w_gidx    = '0;
        w_last    = 1'b0;
        w_pld     = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (w_act[i]) begin
                w_gidx = w_gidx | IDX_W'(i);
                w_last = w_last | in_last[i];
                w_pld  = w_pld | in_pld[i*PLD_W +: PLD_W];
            end
        end
    end

    assign w_hs        = w_gnt_vld & w_take;
    assign in_rdy      = w_gnt & {NUM_IN{w_take}};
    assign lock_active = r_lock_active;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_IN; i++) begin
                for (int j = 0; j < NUM_IN; j++) begin
                    r_age[i][j] <= (j < i);
                end
            end
            r_lock_active <= 1'b0;
            r_lock_idx    <= '0;
            r_hold_vld    <= 1'b0;
            r_hold_idx    <= '0;
        end else begin
            r_hold_vld <= w_gnt_vld & ~w_take;
            r_hold_idx <= w_gidx;
            if (w_hs) begin
                r_lock_active <= ~w_last;
                r_lock_idx    <= w_gidx;
                // Only the closing beat of a packet makes the winner youngest
                if (w_last) begin
                    for (int i = 0; i < NUM_IN; i++) begin
                        for (int j = 0; j < NUM_IN; j++) begin
                            if (w_act[i] && (i != j)) begin
                                r_age[i][j] <= 1'b1;
                                r_age[j][i] <= 1'b0;
                            end
                        end
                    end
                end
            end
        end
    end

    generate
        if (OUT_REG == 0) begin : g_comb
            assign w_take   = out_rdy;
            assign out_vld  = w_gnt_vld;
            assign out_last = w_last;
            assign out_pld  = w_pld;
            assign out_idx  = w_gidx;
        end else begin : g_reg
            logic             r_out_vld;
            logic             r_out_last;
            logic [PLD_W-1:0] r_out_pld;
            logic [IDX_W-1:0] r_out_idx;

            // Slice accepts a new beat whenever it is empty or draining this cycle
            assign w_take = ~r_out_vld | out_rdy;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_out_vld  <= 1'b0;
                    r_out_last <= 1'b0;
                    r_out_pld  <= '0;
                    r_out_idx  <= '0;
                end else if (w_hs) begin
                    r_out_vld  <= 1'b1;
                    r_out_last <= w_last;
                    r_out_pld  <= w_pld;
                    r_out_idx  <= w_gidx;
                end else if (out_rdy) begin
                    r_out_vld  <= 1'b0;
                    r_out_last <= 1'b0;
                    r_out_pld  <= '0;
                    r_out_idx  <= '0;
                end
            end

            assign out_vld  = r_out_vld;
            assign out_last = r_out_last;
            assign out_pld  = r_out_pld;
            assign out_idx  = r_out_idx;
        end
    endgenerate

endmodule

// File: tb/tb_toy_bus_age_arb_lock.sv
// Directed bench for toy_bus_age_arb_lock: rotation, packet lock, grant hold,
// reset mid-packet, registered output slice, and 2/16-input rotation.
module tb_toy_bus_age_arb_lock;
    localparam int P = 77;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [P-1:0] mkp(input int i, input int k);
        return {45'h0, 8'(i), 8'(k), 16'hC0DE};
    endfunction

    // 4-input, combinational output
    logic [3:0]     v4_vld, v4_rdy, v4_last;
    logic [4*P-1:0] v4_pld;
    logic           v4_ovld, v4_ordy, v4_olast, v4_lock;
    logic [P-1:0]   v4_opld;
    logic [1:0]     v4_oidx;

    // 4-input, registered output
    logic [3:0]     r_vld, r_rdy, r_last;
    logic [4*P-1:0] r_pld;
    logic           r_ovld, r_ordy, r_olast, r_lock;
    logic [P-1:0]   r_opld;
    logic [1:0]     r_oidx;

    // 2-input and 16-input rotation builds
    logic [1:0]     v2_vld, v2_rdy;
    logic           v2_ovld, v2_olast, v2_lock;
    logic [7:0]     v2_opld;
    logic [0:0]     v2_oidx;
    logic [15:0]    v16_vld, v16_rdy;
    logic           v16_ovld, v16_olast, v16_lock;
    logic [7:0]     v16_opld;
    logic [3:0]     v16_oidx;

    toy_bus_age_arb_lock #(.NUM_IN(4), .PLD_W(P), .OUT_REG(0)) u4 (
        .clk(clk), .rst(rst), .in_vld(v4_vld), .in_rdy(v4_rdy), .in_last(v4_last),
        .in_pld(v4_pld), .out_vld(v4_ovld), .out_rdy(v4_ordy), .out_last(v4_olast),
        .out_pld(v4_opld), .out_idx(v4_oidx), .lock_active(v4_lock));

    toy_bus_age_arb_lock #(.NUM_IN(4), .PLD_W(P), .OUT_REG(1)) u4r (
        .clk(clk), .rst(rst), .in_vld(r_vld), .in_rdy(r_rdy), .in_last(r_last),
        .in_pld(r_pld), .out_vld(r_ovld), .out_rdy(r_ordy), .out_last(r_olast),
        .out_pld(r_opld), .out_idx(r_oidx), .lock_active(r_lock));

    toy_bus_age_arb_lock #(.NUM_IN(2), .PLD_W(8), .OUT_REG(0)) u2 (
        .clk(clk), .rst(rst), .in_vld(v2_vld), .in_rdy(v2_rdy), .in_last(2'b11),
        .in_pld(16'h0), .out_vld(v2_ovld), .out_rdy(1'b1), .out_last(v2_olast),
        .out_pld(v2_opld), .out_idx(v2_oidx), .lock_active(v2_lock));

    toy_bus_age_arb_lock #(.NUM_IN(16), .PLD_W(8), .OUT_REG(0)) u16 (
        .clk(clk), .rst(rst), .in_vld(v16_vld), .in_rdy(v16_rdy), .in_last(16'hFFFF),
        .in_pld(128'h0), .out_vld(v16_ovld), .out_rdy(1'b1), .out_last(v16_olast),
        .out_pld(v16_opld), .out_idx(v16_oidx), .lock_active(v16_lock));

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    int k0, k1, nout;
    logic hs0, hs1;
    logic [11:0] rdy_pat;

    initial begin
        v4_vld = '0; v4_last = '1; v4_ordy = 1'b1;
        r_vld = '0; r_last = '1; r_ordy = 1'b1; r_pld = '0;
        v2_vld = '0; v16_vld = '0;
        for (int i = 0; i < 4; i++) v4_pld[i*P +: P] = mkp(i, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_ovld", v4_ovld, 0);
        check("rst_lock", v4_lock, 0);
        check("rst_opld", v4_opld, 0);
        check("rst_r_ovld", r_ovld, 0);
        check("rst_r_opld", r_opld, 0);
        check("rst_r_oidx", r_oidx, 0);
        next_cycle();

        // Continuous single-beat requests from everyone: strict rotation
        v4_vld = '1; v2_vld = '1; v16_vld = '1;
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            check("rot4_vld", v4_ovld, 1);
            check("rot4_idx", v4_oidx, c % 4);
            check("rot4_pld", v4_opld, mkp(c % 4, 0));
            check("rot4_rdy", v4_rdy, 4'b0001 << (c % 4));
            check("rot2_idx", v2_oidx, c % 2);
            check("rot16_idx", v16_oidx, c % 16);
            next_cycle();
        end
        v2_vld = '0; v16_vld = '0;

        // Age order now 0,1,2,3: serve 0 and 1 so input 2 becomes oldest
        v4_vld = 4'b0011;
        v4_pld[0*P +: P] = mkp(0, 1);
        v4_pld[1*P +: P] = mkp(1, 1);
        @(negedge clk); check("pre_idx0", v4_oidx, 0); next_cycle();
        @(negedge clk); check("pre_idx1", v4_oidx, 1); next_cycle();

        // 3-beat packet from input 2 with a gap between beats 1 and 2
        v4_vld = 4'b0111; v4_last = 4'b1011; v4_pld[2*P +: P] = mkp(2, 1);
        @(negedge clk);
        check("pkt_b1_idx", v4_oidx, 2);
        check("pkt_b1_lock", v4_lock, 0);
        check("pkt_b1_rdy", v4_rdy, 4'b0100);
        next_cycle();
        v4_vld = 4'b0011;
        @(negedge clk);
        check("pkt_gap_vld", v4_ovld, 0);
        check("pkt_gap_lock", v4_lock, 1);
        check("pkt_gap_rdy", v4_rdy, 4'b0000);
        next_cycle();
        v4_vld = 4'b0111; v4_pld[2*P +: P] = mkp(2, 2);
        @(negedge clk);
        check("pkt_b2_idx", v4_oidx, 2);
        check("pkt_b2_pld", v4_opld, mkp(2, 2));
        check("pkt_b2_lock", v4_lock, 1);
        next_cycle();
        v4_last = 4'b1111; v4_pld[2*P +: P] = mkp(2, 3);
        @(negedge clk);
        check("pkt_b3_idx", v4_oidx, 2);
        check("pkt_b3_last", v4_olast, 1);
        check("pkt_b3_lock", v4_lock, 1);
        next_cycle();
        v4_vld = 4'b0011;
        @(negedge clk);
        check("post_idx0", v4_oidx, 0);
        check("post_lock", v4_lock, 0);
        next_cycle();
        @(negedge clk); check("post_idx1", v4_oidx, 1); next_cycle();

        // Age order now 3,2,0,1: serve 3 so input 0 is older than 3
        v4_vld = 4'b1000;
        @(negedge clk); check("hold_pre_idx", v4_oidx, 3); next_cycle();

        // Grant hold: input 3 stalled for 5 cycles, older input 0 arrives meanwhile
        v4_ordy = 1'b0; v4_pld[3*P +: P] = mkp(3, 5);
        for (int h = 0; h < 5; h++) begin
            if (h >= 1) v4_vld = 4'b1001;
            @(negedge clk);
            check("hold_vld", v4_ovld, 1);
            check("hold_idx", v4_oidx, 3);
            check("hold_pld", v4_opld, mkp(3, 5));
            check("hold_rdy", v4_rdy, 4'b0000);
            next_cycle();
        end
        v4_ordy = 1'b1;
        @(negedge clk);
        check("hold_rel_idx", v4_oidx, 3);
        check("hold_rel_rdy", v4_rdy, 4'b1000);
        next_cycle();
        v4_vld = 4'b0001;
        @(negedge clk); check("hold_next_idx", v4_oidx, 0); next_cycle();

        // Reset mid-packet with input 1 locked
        v4_vld = 4'b0010; v4_last = 4'b1101; v4_pld[1*P +: P] = mkp(1, 7);
        @(negedge clk); check("rlk_b1_idx", v4_oidx, 1); next_cycle();
        v4_vld = 4'b0000; v4_last = 4'b1111;
        @(negedge clk); check("rlk_lock", v4_lock, 1); next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("rlk_after_lock", v4_lock, 0);
        check("rlk_after_vld", v4_ovld, 0);
        next_cycle();
        v4_vld = 4'b1010;
        @(negedge clk); check("rlk_fresh_1", v4_oidx, 1); next_cycle();
        @(negedge clk); check("rlk_fresh_3", v4_oidx, 3); next_cycle();
        v4_vld = 4'b0101;
        @(negedge clk); check("rlk_fresh_0", v4_oidx, 0); next_cycle();
        v4_vld = 4'b0000;

        // Registered slice: inputs 0 and 1 stream, out_rdy stalls every other cycle
        k0 = 0; k1 = 0; nout = 0;
        rdy_pat = 12'b110101011111;
        for (int c = 0; c < 12; c++) begin
            r_vld = 4'b0011;
            r_ordy = rdy_pat[c];
            r_pld[0*P +: P] = mkp(0, k0);
            r_pld[1*P +: P] = mkp(1, k1);
            @(negedge clk);
            if (c == 0) check("oreg_lat0", r_ovld, 0);
            else        check("oreg_full", r_ovld, 1);
            if (r_ovld && r_ordy) begin
                check("oreg_idx", r_oidx, nout % 2);
                check("oreg_pld", r_opld, mkp(nout % 2, nout / 2));
                nout++;
            end
            hs0 = r_vld[0] & r_rdy[0];
            hs1 = r_vld[1] & r_rdy[1];
            next_cycle();
            if (hs0) k0++;
            if (hs1) k1++;
        end
        r_vld = '0;
        check("oreg_count", nout, 8);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
